// File: rtl/netw_arb_pkg.sv
// netw_arb_pkg: shared types and widths for the stream arbiter
package netw_arb_pkg;
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
  localparam int MAC_W = 48;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/netw_stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker starting after last grant
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = last;
    j = last;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last) + i) % N);
      idx = req[j] ? j : idx;
    end
    win = req[idx] ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/netw_stream_arbiter.sv
// netw_stream_arbiter: packet-locked round-robin mux of N Avalon-ST sources onto one sink
module netw_stream_arbiter
  import netw_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W = 32,
  parameter int EMPTY_W = 2
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_sys_i,
  input  logic [N_PORTS*DATA_W-1:0]     in_data_i,
  input  logic [N_PORTS*EMPTY_W-1:0]    in_empty_i,
  input  logic [N_PORTS-1:0]            in_valid_i,
  input  logic [N_PORTS-1:0]            in_sop_i,
  input  logic [N_PORTS-1:0]            in_eop_i,
  output logic [N_PORTS-1:0]            in_ready_o,
  input  logic [N_PORTS*MAC_W-1:0]      mac_dst_tbl_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [EMPTY_W-1:0]            out_empty_o,
  output logic                          out_valid_o,
  output logic                          out_sop_o,
  output logic                          out_eop_o,
  input  logic                          out_ready_i,
  output logic [MAC_W-1:0]              mac_dst_o,
  output logic [N_PORTS-1:0]            grant_o,
  output logic                          busy_o,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o
);
  localparam int IW = $clog2(N_PORTS);
  state_t state;
  logic [IW-1:0] last, pick_idx;
  logic [N_PORTS-1:0] pick_oh;
  logic pkt, drp, acc_eop;
  rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
    .req  (in_valid_i),
    .last (last),
    .win  (pick_oh),
    .idx  (pick_idx)
  );
  assign pkt = state == PKT;
  assign drp = state == DROP;
  assign busy_o = state != IDLE;
  assign out_valid_o = pkt & in_valid_i[last];
  assign out_sop_o = pkt & in_sop_i[last];
  assign out_eop_o = pkt & in_eop_i[last];
  assign out_data_o = pkt ? in_data_i[int'(last)*DATA_W +: DATA_W] : '0;
  assign out_empty_o = pkt ? in_empty_i[int'(last)*EMPTY_W +: EMPTY_W] : '0;
  assign in_ready_o = pkt ? grant_o & {N_PORTS{out_ready_i}} : drp ? grant_o : '0;
  assign acc_eop = busy_o & in_valid_i[last] & in_ready_o[last] & in_eop_i[last];
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state <= IDLE;
      grant_o <= '0;
      last <= IW'(N_PORTS - 1);
      mac_dst_o <= '0;
      drop_cnt_o <= '0;
    end else if (state == IDLE) begin
      if (|in_valid_i) begin
        state <= in_sop_i[pick_idx] ? PKT : DROP;
        grant_o <= pick_oh;
        last <= pick_idx;
        mac_dst_o <= mac_dst_tbl_i[int'(pick_idx)*MAC_W +: MAC_W];
      end
    end else if (acc_eop) begin
      state <= IDLE;
      grant_o <= '0;
      mac_dst_o <= '0;
      if (drp && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_netw_stream_arbiter.sv
// tb_netw_stream_arbiter: directed scoreboard bench for the stream arbiter
module tb_netw_stream_arbiter;
  typedef struct {
    logic [31:0] d;
    logic [1:0]  e;
    logic        s;
    logic        p;
  } beat_t;
  typedef struct {
    beat_t       b;
    int          port;
    logic [47:0] mac;
  } sb_t;
  logic clk, rst, out_ready;
  logic [127:0] in_data;
  logic [7:0] in_empty;
  logic [3:0] in_valid, in_sop, in_eop, in_ready, grant, acc;
  logic [191:0] tbl;
  logic [31:0] out_data;
  logic [1:0] out_empty;
  logic out_valid, out_sop, out_eop, busy;
  logic [47:0] mac_dst;
  logic [15:0] drop_cnt;
  beat_t src[4][$];
  sb_t sb[$];
  sb_t mon_e;
  int checks = 0, passes = 0, seq = 0;
  logic done;
  netw_stream_arbiter #(.N_PORTS(4), .DATA_W(32), .EMPTY_W(2)) dut (
    .clk_sys_i     (clk),
    .rst_sys_i     (rst),
    .in_data_i     (in_data),
    .in_empty_i    (in_empty),
    .in_valid_i    (in_valid),
    .in_sop_i      (in_sop),
    .in_eop_i      (in_eop),
    .in_ready_o    (in_ready),
    .mac_dst_tbl_i (tbl),
    .out_data_o    (out_data),
    .out_empty_o   (out_empty),
    .out_valid_o   (out_valid),
    .out_sop_o     (out_sop),
    .out_eop_o     (out_eop),
    .out_ready_i   (out_ready),
    .mac_dst_o     (mac_dst),
    .grant_o       (grant),
    .busy_o        (busy),
    .drop_cnt_o    (drop_cnt)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", {32'h0, out_data}, 64'hDEAD);
      else begin
        mon_e = sb.pop_front();
        chk("beat_data", out_data, mon_e.b.d);
        chk("beat_empty", out_empty, mon_e.b.e);
        chk("beat_sop_eop", {out_sop, out_eop}, {mon_e.b.s, mon_e.b.p});
        chk("beat_grant", grant, 64'(1) << mon_e.port);
        chk("beat_mac", mac_dst, mon_e.mac);
      end
    end
  end
  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (src[k].size() > 0) begin
        in_valid[k] = 1'b1;
        in_data[k*32 +: 32] = src[k][0].d;
        in_empty[k*2 +: 2] = src[k][0].e;
        in_sop[k] = src[k][0].s;
        in_eop[k] = src[k][0].p;
      end else begin
        in_valid[k] = 1'b0;
        in_data[k*32 +: 32] = '0;
        in_empty[k*2 +: 2] = '0;
        in_sop[k] = 1'b0;
        in_eop[k] = 1'b0;
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (acc[k] && src[k].size() > 0) void'(src[k].pop_front());
    drive();
    #1;
  endtask
  task automatic add_pkt(input int p, input int n, input logic s0, input logic [1:0] emp, input logic fwd);
    beat_t b;
    sb_t e;
    seq++;
    for (int i = 0; i < n; i++) begin
      b.d = 32'hA000_0000 | (p << 16) | (seq << 8) | i;
      b.s = (i == 0) && s0;
      b.p = i == n - 1;
      b.e = (i == n - 1) ? emp : 2'd0;
      src[p].push_back(b);
      e.b = b;
      e.port = p;
      e.mac = tbl[p*48 +: 48];
      if (fwd) sb.push_back(e);
    end
    drive();
    #1;
  endtask
  task automatic clear_all();
    for (int k = 0; k < 4; k++) src[k].delete();
    sb.delete();
    drive();
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    clear_all();
    #1;
  endtask
  task automatic wait_done(input string tag, input int budget);
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = !busy && src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0 && src[3].size() == 0;
    end
    chk(tag, done, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_idle_grant"}, grant, 0);
  endtask
  initial begin
    rst = 1;
    out_ready = 1;
    tbl = '0;
    for (int k = 0; k < 4; k++) tbl[k*48 +: 48] = 48'h0200_0000_0000 | 48'(k);
    tbl[2*48 +: 48] = 48'h0A0B0C0D0E0F;
    drive();
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_ctl", {out_valid, out_sop, out_eop}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mac", mac_dst, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    add_pkt(2, 3, 1, 2'd1, 1);
    chk("t1_no_grant_yet", grant, 0);
    tick();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_busy", busy, 1);
    chk("t1_mac", mac_dst, 48'h0A0B0C0D0E0F);
    wait_done("t1_done", 20);
    do_reset();
    add_pkt(0, 2, 1, 2'd0, 1);
    add_pkt(1, 2, 1, 2'd0, 1);
    add_pkt(2, 2, 1, 2'd0, 1);
    add_pkt(3, 2, 1, 2'd0, 1);
    add_pkt(0, 2, 1, 2'd3, 1);
    tick();
    chk("t2_first_grant", grant, 4'b0001);
    wait_done("t2_done", 40);
    add_pkt(1, 4, 1, 2'd2, 1);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      out_ready = (i % 2) == 0;
      #1;
      if (grant[1]) chk("t3_ready_mirror", in_ready, {2'b00, out_ready, 1'b0});
      tick();
      done = !busy && src[1].size() == 0;
    end
    out_ready = 1;
    chk("t3_done", done, 1);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t4_drop_cnt_before", drop_cnt, 0);
    add_pkt(3, 2, 0, 2'd0, 0);
    add_pkt(1, 2, 1, 2'd0, 1);
    tick();
    chk("t4_grant_drop", grant, 4'b1000);
    chk("t4_out_valid", out_valid, 0);
    out_ready = 0;
    #1;
    chk("t4_sink_ready", in_ready, 4'b1000);
    out_ready = 1;
    wait_done("t4_done", 20);
    chk("t4_drop_cnt_after", drop_cnt, 1);
    add_pkt(0, 1, 1, 2'd2, 1);
    add_pkt(0, 1, 1, 2'd2, 1);
    tick();
    chk("t5_grant", grant, 4'b0001);
    chk("t5_out_ctl", {out_valid, out_sop, out_eop, out_empty}, 5'b11110);
    tick();
    chk("t5_bubble", {busy, grant}, 0);
    chk("t5_bubble_valid", out_valid, 0);
    tick();
    chk("t5_regrant", grant, 4'b0001);
    wait_done("t5_done", 10);
    add_pkt(2, 4, 1, 2'd0, 1);
    tick();
    tick();
    tick();
    chk("t6_mid_pkt", grant, 4'b0100);
    out_ready = 0;
    rst = 1;
    tick();
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_out_ctl", {out_valid, out_sop, out_eop}, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_mac", mac_dst, 0);
    chk("t6_rst_drop_cnt", drop_cnt, 0);
    rst = 0;
    clear_all();
    out_ready = 1;
    add_pkt(0, 2, 1, 2'd0, 1);
    add_pkt(1, 2, 1, 2'd0, 1);
    tick();
    chk("t6_port0_first", grant, 4'b0001);
    wait_done("t6_done", 20);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/netw_stream_arbiter.md
# netw_stream_arbiter

Packet-granular round-robin arbiter that shares the single Avalon-ST ingress of the network TX/RX core between `N_PORTS` requesters on the system clock domain. It locks the grant from start-of-packet to end-of-packet, so packets are never interleaved. It presents the winning requester's per-port destination MAC to the core's `mac_dst_i`. Malformed packets that start without `sop` are discarded and counted.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesting streams, 2..8.
- `DATA_W`, 32: beat width.
- `EMPTY_W`, 2: width of the empty field.

Ports:
- `clk_sys_i`  in  1  system clock.
- `rst_sys_i`  in  1  synchronous, active-high reset.
- `in_data_i`  in  N_PORTS*DATA_W  requester data, port k at bits [k*DATA_W +: DATA_W].
- `in_empty_i`  in  N_PORTS*EMPTY_W  requester empty, packed the same way.
- `in_valid_i`, `in_sop_i`, `in_eop_i`  in  N_PORTS  per-port valid, startofpacket and endofpacket.
- `in_ready_o`  out  N_PORTS  per-port ready.
- `mac_dst_tbl_i`  in  N_PORTS*48  per-port destination MAC, quasi-static.
- `out_data_o`  out  DATA_W  data to the core's `data_i`.
- `out_empty_o`  out  EMPTY_W  empty to the core.
- `out_valid_o`, `out_sop_o`, `out_eop_o`  out  1  to the core.
- `out_ready_i`  in  1  from the core's `ready_in_o`.
- `mac_dst_o`  out  48  to the core's `mac_dst_i`.
- `grant_o`  out  N_PORTS  one-hot grant, all zeros when idle.
- `busy_o`  out  1  high in PKT or DROP.
- `drop_cnt_o`  out  16  count of discarded packets, saturating.

## Operation
States:
- IDLE: no grant. If any `in_valid_i` is set, the round-robin picker selects port p. The search starts at `last_grant+1` mod N_PORTS. On the next edge the block registers `grant=p`, `last_grant=p` and `mac_dst_o=tbl[p]`. It then enters PKT if `in_sop_i[p]` is high, otherwise DROP.
- PKT: `out_*` is a combinational mux of port p, with `out_valid_o = in_valid_i[p]`. `in_ready_o[p] = out_ready_i`; all other readies are 0. A beat is accepted when `valid && ready`. When the accepted beat has `eop`, the block returns to IDLE.
- DROP: `in_ready_o[p] = 1` and `out_valid_o = 0`, so beats are sunk. When the accepted beat has `eop`, `drop_cnt_o` increments (saturating at 0xFFFF) and the block returns to IDLE.

Rules:
- `sop` seen mid-packet in PKT is forwarded unchanged; it is not re-checked.
- `mac_dst_o` is held stable for the entire packet. Table changes take effect only at the next grant.
- A requester that drops `valid` mid-packet keeps the grant; the arbiter waits for it.
- A single-beat packet (`sop` and `eop` on the same beat) is legal: PKT lasts one accepted beat.

## Timing
- Reset values: state IDLE, `grant_o=0`, `busy_o=0`, `out_valid_o=0`, `out_sop_o=0`, `out_eop_o=0`, `in_ready_o=0`, `mac_dst_o=0`, `drop_cnt_o=0`. `last_grant=N_PORTS-1`, so port 0 wins first.
- Arbitration latency: one cycle from valid in IDLE to the grant being registered.
- Data latency: 0 cycles through the mux; `out_*` follows the granted port combinationally.
- Packet boundary: every packet is followed by one IDLE bubble cycle. Peak throughput is L/(L+1) for L-beat packets.
- The in-IDLE outputs are all 0, and `out_valid_o` never asserts outside PKT.
- Simultaneous requests: strictly rotating priority. No port waits more than N_PORTS-1 packets.
- Reset mid-packet: immediate return to IDLE. The partial packet is abandoned and the counter is cleared.

## Structure
- Package `netw_arb_pkg`:
  - state enum {IDLE, PKT, DROP};
  - `MAC_W=48`;
  - `DROP_CNT_W=16`.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and `last_grant`. Outputs are a one-hot winner and its index.
- The top level holds the FSM, the grant and MAC registers, the muxes and the counter.

## Test plan
- Reset, then port 2 sends a 3-beat packet (`sop`, data, `eop`) with `tbl[2]=0x0A0B0C0D0E0F`. Expect `grant_o=0100` one cycle after valid, three beats out unchanged, `mac_dst_o=0x0A0B0C0D0E0F` throughout, then IDLE.
- All 4 ports continuously valid with 2-beat packets. Expect grant order 0,1,2,3,0 and no interleaved beats.
- `out_ready_i` toggled 1010 during a 4-beat packet on port 1. Expect each beat held until accepted, and `in_ready_o[1]` mirroring `out_ready_i`.
- Port 3 starts with a beat lacking `sop` and ends with `eop` after 2 beats. Expect `out_valid_o=0` throughout, `drop_cnt_o` going 0→1, then the next port served.
- Single-beat packet on port 0 (`sop=eop=1`, `empty=2`). Expect one output beat with `empty=2`, then one bubble cycle before the next grant.
- `rst_sys_i` asserted mid-packet. Expect all outputs at reset values on the next cycle, then port 0 granted first.
